// File: rtl/mac_sequencer_if.sv
// Bundles the operand stream, the multiplier start/Ready link and the result stream.
// master is the sequencer's view; slave is the surrounding environment's view.
interface mac_sequencer_if #(
  parameter int DP_WIDTH  = 5,
  parameter int ACC_WIDTH = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DP_WIDTH-1:0]     in_a;
  logic [DP_WIDTH-1:0]     in_b;
  logic                    mul_start;
  logic [DP_WIDTH-1:0]     mul_multiplicand;
  logic [DP_WIDTH-1:0]     mul_multiplier;
  logic [2*DP_WIDTH-1:0]   mul_product;
  logic                    mul_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_WIDTH-1:0]    acc_sum;
  logic                    overflow;

  modport master (
    input  in_valid, in_a, in_b, mul_product, mul_ready, out_ready,
    output in_ready, mul_start, mul_multiplicand, mul_multiplier,
           out_valid, acc_sum, overflow
  );

  modport slave (
    output in_valid, in_a, in_b, mul_product, mul_ready, out_ready,
    input  in_ready, mul_start, mul_multiplicand, mul_multiplier,
           out_valid, acc_sum, overflow
  );
endinterface

// File: rtl/mac_sequencer.sv
// Feeds operand pairs to an external start/Ready multiplier and accumulates N_TERMS
// products into a dot-product sum. Optional macro SATURATE_EN clamps the sum on overflow.
module mac_sequencer #(
  parameter int DP_WIDTH  = 5,
  parameter int N_TERMS   = 4,
  parameter int ACC_WIDTH = 12
) (
  input  logic            clock,
  input  logic            reset,
  mac_sequencer_if.master bus
);
  localparam int CNT_W  = $clog2(N_TERMS + 1);
  localparam int PROD_W = 2 * DP_WIDTH;

  typedef enum logic [2:0] {
    IDLE, START, WAIT_BUSY, WAIT_DONE, ACC, OUT
  } state_t;

  state_t                state_q, state_d;
  logic [DP_WIDTH-1:0]   a_q, a_d;
  logic [DP_WIDTH-1:0]   b_q, b_d;
  logic [PROD_W-1:0]     prod_q, prod_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [ACC_WIDTH:0]    sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // The extra top bit of sum is the carry that flags overflow.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    sum     = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PROD_W){1'b0}}, prod_q};

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.mul_ready) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          state_d = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!bus.mul_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.mul_ready) begin
          prod_d  = bus.mul_product;
          state_d = ACC;
        end
      end
      ACC: begin
        count_d = count_q + CNT_W'(1);
        ovf_d   = ovf_q | sum[ACC_WIDTH];
`ifdef SATURATE_EN
        acc_d   = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
        acc_d   = sum[ACC_WIDTH-1:0];
`endif
        state_d = (count_q == CNT_W'(N_TERMS - 1)) ? OUT : IDLE;
      end
      OUT: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is masked while reset is held so nothing is offered during reset.
  assign bus.in_ready         = (state_q == IDLE) && bus.mul_ready && !reset;
  assign bus.mul_start        = (state_q == START);
  assign bus.mul_multiplicand = a_q;
  assign bus.mul_multiplier   = b_q;
  assign bus.out_valid        = (state_q == OUT);
  assign bus.acc_sum          = acc_q;
  assign bus.overflow         = ovf_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer: behavioural multiplier plus a dot-product reference model.
// Honors SATURATE_EN the same way the design build does.
module tb_mac_sequencer;
  localparam int DP        = 5;
  localparam int NT        = 4;
  localparam int AW        = 10;
  localparam int ACC_LIMIT = 1 << AW;

  typedef int pairArr_t [NT];

  logic clock = 1'b0;
  logic reset;
  logic mulReset;
  int   vectors = 0;
  int   miscompares = 0;

  mac_sequencer_if #(.DP_WIDTH(DP), .ACC_WIDTH(AW)) bus ();

  mac_sequencer #(.DP_WIDTH(DP), .N_TERMS(NT), .ACC_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Shift-add multiplier stand-in: drops Ready the edge after start, returns a*b later.
  logic          mulBusy;
  int            mulLeft;
  logic [DP-1:0] mulA, mulB;
  int            mulLatMin = 1;
  int            mulLatMax = 5;
  logic [2*DP-1:0] mulLog [$];

  always @(posedge clock) begin
    if (mulReset) begin
      bus.mul_ready   <= 1'b1;
      bus.mul_product <= '0;
      mulBusy         <= 1'b0;
      mulLeft         <= 0;
    end else if (mulBusy) begin
      if (mulLeft <= 1) begin
        bus.mul_ready   <= 1'b1;
        bus.mul_product <= (2*DP)'(mulA) * (2*DP)'(mulB);
        mulBusy         <= 1'b0;
      end else begin
        mulLeft <= mulLeft - 1;
      end
    end else if (bus.mul_start) begin
      bus.mul_ready   <= 1'b0;
      bus.mul_product <= 10'h2AA;
      mulBusy         <= 1'b1;
      mulLeft         <= $urandom_range(mulLatMax, mulLatMin);
      mulA            <= bus.mul_multiplicand;
      mulB            <= bus.mul_multiplier;
      mulLog.push_back({bus.mul_multiplicand, bus.mul_multiplier});
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Dot product from plain integer arithmetic, wrapping or clamping whenever the limit is crossed.
  function automatic void refModel(input pairArr_t a, input pairArr_t b,
                                   output int sumE, output bit ovfE);
    int acc;
    acc  = 0;
    ovfE = 1'b0;
    for (int i = 0; i < NT; i++) begin
      acc = acc + a[i] * b[i];
      if (acc >= ACC_LIMIT) begin
        ovfE = 1'b1;
`ifdef SATURATE_EN
        acc = ACC_LIMIT - 1;
`else
        acc = acc - ACC_LIMIT;
`endif
      end
    end
    sumE = acc;
  endfunction

  task automatic sendPair(input int a, input int b, output bit timedOut);
    int n;
    n = 0;
    timedOut = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = DP'(a);
    bus.in_b = DP'(b);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) timedOut = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitOut(output bit timedOut);
    int n;
    n = 0;
    timedOut = 1'b0;
    while (bus.out_valid !== 1'b1 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) timedOut = 1'b1;
  endtask

  task automatic runGroup(input pairArr_t a, input pairArr_t b,
                          output int sumObs, output bit ovfObs, output bit timedOut);
    bit to;
    timedOut = 1'b0;
    for (int i = 0; i < NT; i++) begin
      sendPair(a[i], b[i], to);
      timedOut |= to;
    end
    waitOut(to);
    timedOut |= to;
    sumObs = int'(bus.acc_sum);
    ovfObs = bus.overflow;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mulReset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 5'd9;
    bus.in_b = 5'd9;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    vectors += 6;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    if (bus.mul_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mul_start: got %b expected 0", bus.mul_start); end
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.acc_sum !== '0) begin miscompares++; $display("[TB] FAIL reset_acc_sum: got %0d expected 0", bus.acc_sum); end
    if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
    if (bus.mul_multiplicand !== '0 || bus.mul_multiplier !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_operands: got %0d,%0d expected 0,0", bus.mul_multiplicand, bus.mul_multiplier);
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    mulReset = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_directed_sum;
    pairArr_t a, b;
    int sumObs;
    bit ovfObs, to;
    a = '{3, 31, 0, 10};
    b = '{5, 31, 7, 2};
    runGroup(a, b, sumObs, ovfObs, to);
    vectors += 2;
    if (to || sumObs !== 996) begin miscompares++; $display("[TB] FAIL directed_sum: got %0d (timeout=%b) expected 996", sumObs, to); end
    if (ovfObs !== 1'b0) begin miscompares++; $display("[TB] FAIL directed_overflow: got %b expected 0", ovfObs); end
  endtask

  task automatic test_output_hold;
    bit to, anyTo;
    int holdErr;
    anyTo = 1'b0;
    holdErr = 0;
    sendPair(3, 5, to);   anyTo |= to;
    sendPair(31, 31, to); anyTo |= to;
    sendPair(0, 7, to);   anyTo |= to;
    sendPair(10, 2, to);  anyTo |= to;
    waitOut(to);          anyTo |= to;
    bus.in_valid = 1'b1;
    bus.in_a = 5'd4;
    bus.in_b = 5'd4;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (anyTo || bus.out_valid !== 1'b1 || bus.acc_sum !== AW'(996) || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b sum=%0d in_ready=%b expected 1/996/0",
                 i, bus.out_valid, bus.acc_sum, bus.in_ready);
      end
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    vectors += 3;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL release_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.acc_sum !== '0) begin miscompares++; $display("[TB] FAIL release_acc_sum: got %0d expected 0", bus.acc_sum); end
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_start_pulse;
    pairArr_t a, b;
    int sumE, starts, n;
    bit ovfE, to, stableOk;
    for (int i = 0; i < NT; i++) begin
      a[i] = int'($urandom_range(31, 0));
      b[i] = int'($urandom_range(31, 0));
      sendPair(a[i], b[i], to);
      starts = 0;
      stableOk = 1'b1;
      n = 0;
      do begin
        if (bus.mul_start === 1'b1) starts++;
        if (bus.mul_multiplicand !== DP'(a[i]) || bus.mul_multiplier !== DP'(b[i])) stableOk = 1'b0;
        @(negedge clock);
        n++;
      end while (bus.in_ready !== 1'b1 && bus.out_valid !== 1'b1 && n < 100);
      vectors += 2;
      if (to || starts !== 1) begin miscompares++; $display("[TB] FAIL start_pulse_term%0d: got %0d cycles expected 1", i, starts); end
      if (!stableOk) begin miscompares++; $display("[TB] FAIL operand_stable_term%0d: got unstable expected %0d,%0d", i, a[i], b[i]); end
    end
    refModel(a, b, sumE, ovfE);
    waitOut(to);
    vectors++;
    if (to || int'(bus.acc_sum) !== sumE || bus.overflow !== ovfE) begin
      miscompares++;
      $display("[TB] FAIL start_group_sum: got %0d/%b expected %0d/%b", bus.acc_sum, bus.overflow, sumE, ovfE);
    end
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    pairArr_t a, b;
    int sumObs, expSum;
    bit ovfObs, to;
    a = '{31, 31, 31, 31};
    b = '{31, 31, 31, 31};
`ifdef SATURATE_EN
    expSum = 1023;
`else
    expSum = 772;
`endif
    runGroup(a, b, sumObs, ovfObs, to);
    vectors += 2;
    if (to || sumObs !== expSum) begin miscompares++; $display("[TB] FAIL overflow_sum: got %0d expected %0d", sumObs, expSum); end
    if (ovfObs !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_flag: got %b expected 1", ovfObs); end
  endtask

  task automatic test_reset_midop;
    pairArr_t a, b;
    int sumObs, n;
    bit ovfObs, to;
    mulLatMin = 6;
    mulLatMax = 6;
    sendPair(1, 1, to);
    sendPair(1, 1, to);
    n = 0;
    while (bus.mul_ready !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    vectors += 5;
    if (to || bus.out_valid !== 1'b0 || bus.mul_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midop_ctrl: got valid=%b start=%b expected 0/0", bus.out_valid, bus.mul_start);
    end
    if (bus.acc_sum !== '0) begin miscompares++; $display("[TB] FAIL midop_acc_sum: got %0d expected 0", bus.acc_sum); end
    if (bus.overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL midop_overflow: got %b expected 0", bus.overflow); end
    if (bus.mul_multiplicand !== '0 || bus.mul_multiplier !== '0) begin
      miscompares++;
      $display("[TB] FAIL midop_operands: got %0d,%0d expected 0,0", bus.mul_multiplicand, bus.mul_multiplier);
    end
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL midop_in_ready: got %b expected 0", bus.in_ready); end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_after_reset_in_ready: got %b expected 0", bus.in_ready); end
    mulLatMin = 1;
    mulLatMax = 5;
    a = '{1, 1, 1, 1};
    b = '{1, 1, 1, 1};
    runGroup(a, b, sumObs, ovfObs, to);
    vectors++;
    if (to || sumObs !== 4 || ovfObs !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_sum: got %0d/%b expected 4/0", sumObs, ovfObs);
    end
  endtask

  task automatic test_random_groups;
    pairArr_t a, b;
    int sumObs, sumE;
    bit ovfObs, ovfE, to;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < NT; i++) begin
        a[i] = int'($urandom_range(31, 0));
        b[i] = int'($urandom_range(31, 0));
      end
      refModel(a, b, sumE, ovfE);
      runGroup(a, b, sumObs, ovfObs, to);
      vectors++;
      if (to || sumObs !== sumE || ovfObs !== ovfE) begin
        miscompares++;
        $display("[TB] FAIL random_group%0d: got %0d/%b expected %0d/%b", g, sumObs, ovfObs, sumE, ovfE);
      end
    end
  endtask

  task automatic test_back_to_back;
    pairArr_t ga [3];
    pairArr_t gb [3];
    int sumsQ [$];
    bit ovfQ [$];
    int idx, logStart, sumE;
    bit accept, ovfE, pairsOk;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < NT; i++) begin
        ga[g][i] = int'($urandom_range(31, 0));
        gb[g][i] = int'($urandom_range(31, 0));
      end
    end
    logStart = mulLog.size();
    idx = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = DP'(ga[0][0]);
    bus.in_b = DP'(gb[0][0]);
    for (int cyc = 0; cyc < 3000 && sumsQ.size() < 3; cyc++) begin
      accept = (bus.in_ready === 1'b1 && bus.in_valid === 1'b1);
      if (bus.out_valid === 1'b1) begin
        sumsQ.push_back(int'(bus.acc_sum));
        ovfQ.push_back(bus.overflow);
      end
      @(negedge clock);
      if (accept) begin
        idx++;
        if (idx < 3 * NT) begin
          bus.in_a = DP'(ga[idx / NT][idx % NT]);
          bus.in_b = DP'(gb[idx / NT][idx % NT]);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    vectors++;
    if (sumsQ.size() !== 3) begin miscompares++; $display("[TB] FAIL b2b_group_count: got %0d expected 3", sumsQ.size()); end
    for (int g = 0; g < 3 && g < sumsQ.size(); g++) begin
      refModel(ga[g], gb[g], sumE, ovfE);
      vectors++;
      if (sumsQ[g] !== sumE || ovfQ[g] !== ovfE) begin
        miscompares++;
        $display("[TB] FAIL b2b_group%0d: got %0d/%b expected %0d/%b", g, sumsQ[g], ovfQ[g], sumE, ovfE);
      end
    end
    pairsOk = (mulLog.size() - logStart == 3 * NT);
    for (int k = 0; pairsOk && k < 3 * NT; k++)
      if (mulLog[logStart + k] !== {DP'(ga[k / NT][k % NT]), DP'(gb[k / NT][k % NT])}) pairsOk = 1'b0;
    vectors++;
    if (!pairsOk) begin
      miscompares++;
      $display("[TB] FAIL b2b_pairs: got %0d multiplies or wrong operands expected %0d in order",
               mulLog.size() - logStart, 3 * NT);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    mulReset = 1'b1;
    @(negedge clock);
    test_reset();
    test_directed_sum();
    test_output_hold();
    test_start_pulse();
    test_overflow();
    test_reset_midop();
    test_random_groups();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
